// File: rtl/write_buffer_ctrl_if.sv
// Bus bundle between the CPU/cache store path, the write buffer controller and main memory.
// The slave modport is the controller's view; master is the surrounding system.
interface write_buffer_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              Mem_Wr;
   logic [ADDR_W-1:0] Wr_Addr;
   logic [DATA_W-1:0] Wr_Data;
   logic              Rd_Miss_Req;
   logic [ADDR_W-1:0] Rd_Addr;
   logic              Rd_Done;
   logic              Main_Wr;
   logic              Main_Rd;
   logic [ADDR_W-1:0] Main_Addr;
   logic [DATA_W-1:0] Main_WData;
   logic              Main_Ready;
   logic              wb_full;
   logic              wb_empty;
   logic              stall;

   modport master (
      output Mem_Wr, Wr_Addr, Wr_Data, Rd_Miss_Req, Rd_Addr, Main_Ready,
      input  Rd_Done, Main_Wr, Main_Rd, Main_Addr, Main_WData, wb_full, wb_empty, stall
   );

   modport slave (
      input  Mem_Wr, Wr_Addr, Wr_Data, Rd_Miss_Req, Rd_Addr, Main_Ready,
      output Rd_Done, Main_Wr, Main_Rd, Main_Addr, Main_WData, wb_full, wb_empty, stall
   );
endinterface

// File: rtl/write_buffer_ctrl.sv
// Write-through store buffer with a single-ported main-memory scheduler.
// Refill reads win over drains unless the read address matches a queued store.
module write_buffer_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic CLK,
   input  logic rst,
   write_buffer_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;
   logic              entry_hit;
   logic              raw_hit;

   // An entry is live when its distance from the head is below the occupancy.
   function automatic logic is_valid(input logic [PTR_W-1:0] idx,
                                     input logic [PTR_W-1:0] head,
                                     input logic [CNT_W-1:0] cnt);
      logic [PTR_W-1:0] offs;
      offs = idx - head;
      return ({1'b0, offs} < cnt);
   endfunction

   assign bus.wb_full  = (count == CNT_W'(DEPTH));
   assign bus.wb_empty = (count == '0);
   assign bus.stall    = bus.Mem_Wr && bus.wb_full;
   assign push         = bus.Mem_Wr && !bus.wb_full;
   assign pop          = (state == WRITE) && bus.Main_Ready;
   assign bus.Rd_Done  = !rst && (state == READ) && bus.Main_Ready;

   always_comb begin
      entry_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (is_valid(PTR_W'(i), rd_ptr, count) && (addr_mem[i] == bus.Rd_Addr))
            entry_hit = 1'b1;
      end
   end

   // A store landing this very cycle also blocks a read to the same word.
   assign raw_hit = entry_hit || (push && (bus.Wr_Addr == bus.Rd_Addr));

   always_ff @(posedge CLK) begin
      if (push) begin
         addr_mem[wr_ptr] <= bus.Wr_Addr;
         data_mem[wr_ptr] <= bus.Wr_Data;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state          <= IDLE;
         bus.Main_Wr    <= 1'b0;
         bus.Main_Rd    <= 1'b0;
         bus.Main_Addr  <= '0;
         bus.Main_WData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Rd_Miss_Req && !raw_hit) begin
                  state         <= READ;
                  bus.Main_Rd   <= 1'b1;
                  bus.Main_Addr <= bus.Rd_Addr;
               end else if (!bus.wb_empty) begin
                  state          <= WRITE;
                  bus.Main_Wr    <= 1'b1;
                  bus.Main_Addr  <= addr_mem[rd_ptr];
                  bus.Main_WData <= data_mem[rd_ptr];
               end
            end
            READ: begin
               if (bus.Main_Ready) begin
                  state       <= IDLE;
                  bus.Main_Rd <= 1'b0;
               end
            end
            WRITE: begin
               if (bus.Main_Ready) begin
                  state       <= IDLE;
                  bus.Main_Wr <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               bus.Main_Wr <= 1'b0;
               bus.Main_Rd <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_write_buffer_ctrl.sv
// Self-checking bench for write_buffer_ctrl: table-driven stores plus hand-written
// read/drain ordering, back-pressure and reset sequences, checked through a scoreboard.
module tb_write_buffer_ctrl;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic CLK;
   logic rst;

   write_buffer_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc();

   write_buffer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .CLK(CLK),
      .rst(rst),
      .bus(ifc)
   );

   typedef struct {
      logic              is_rd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } txn_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                lat;
      bit                burst;
      logic              exp_empty;
   } vec_t;

   txn_t sb[$];
   vec_t vt[7];
   int   checks;
   int   failures;
   int   rd_done_cnt;
   int   wait_cnt;
   int   mem_lat;
   bit   mem_en;
   bit   force_ready;
   bit   drop_rd;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // One clock: monitor outputs on the falling edge, then play the memory side.
   task automatic tick();
      txn_t e;
      @(negedge CLK);
      if (!rst) begin
         if (ifc.Main_Wr && ifc.Main_Rd) begin
            checks++;
            failures++;
            $display("FAIL excl: Main_Wr=1 and Main_Rd=1 together, required at most one");
         end
         if (ifc.Main_Ready && (ifc.Main_Wr || ifc.Main_Rd)) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL txn: got rd=%0b addr=%0h, required no transaction",
                        ifc.Main_Rd, ifc.Main_Addr);
            end else begin
               e = sb.pop_front();
               if (e.is_rd !== ifc.Main_Rd || e.addr !== ifc.Main_Addr ||
                   (!e.is_rd && e.data !== ifc.Main_WData)) begin
                  failures++;
                  $display("FAIL txn: got rd=%0b addr=%0h data=%0h required rd=%0b addr=%0h data=%0h",
                           ifc.Main_Rd, ifc.Main_Addr, ifc.Main_WData, e.is_rd, e.addr, e.data);
               end
            end
         end
         if (ifc.Rd_Done) begin
            rd_done_cnt++;
            drop_rd = 1'b1;
            checks++;
            if (!(ifc.Main_Rd && ifc.Main_Ready)) begin
               failures++;
               $display("FAIL rd_done: got pulse with Main_Rd=%0b Main_Ready=%0b, required both 1",
                        ifc.Main_Rd, ifc.Main_Ready);
            end
         end else if (ifc.Main_Rd && ifc.Main_Ready) begin
            checks++;
            failures++;
            $display("FAIL rd_done: got 0 on read completion, required 1");
         end
      end
      @(posedge CLK);
      #1;
      if (drop_rd) begin
         ifc.Rd_Miss_Req = 1'b0;
         drop_rd = 1'b0;
      end
      if (!mem_en) begin
         ifc.Main_Ready = force_ready;
         wait_cnt = 0;
      end else if (ifc.Main_Ready) begin
         ifc.Main_Ready = 1'b0;
         wait_cnt = 0;
      end else if (ifc.Main_Wr || ifc.Main_Rd) begin
         wait_cnt++;
         if (wait_cnt >= mem_lat) ifc.Main_Ready = 1'b1;
      end else begin
         wait_cnt = 0;
      end
   endtask

   task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit track);
      ifc.Mem_Wr  = 1'b1;
      ifc.Wr_Addr = a;
      ifc.Wr_Data = d;
      if (track) sb.push_back('{is_rd: 1'b0, addr: a, data: d});
      #1;
      chk("store_no_stall", {63'd0, ifc.stall}, 64'd0);
      tick();
      ifc.Mem_Wr = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int  n;
      bit  busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < budget) begin
         busy = (sb.size() != 0) || !ifc.wb_empty || ifc.Main_Wr || ifc.Main_Rd || ifc.Rd_Miss_Req;
         if (busy) begin
            tick();
            n++;
         end
      end
      busy = (sb.size() != 0) || !ifc.wb_empty || ifc.Main_Wr || ifc.Main_Rd || ifc.Rd_Miss_Req;
      checks++;
      if (busy) begin
         failures++;
         $display("FAIL %s: got pending=%0d empty=%0b after %0d cycles, required all drained",
                  name, sb.size(), ifc.wb_empty, budget);
         sb.delete();
      end
   endtask

   initial begin
      int base;
      int n;
      checks = 0;
      failures = 0;
      rd_done_cnt = 0;
      wait_cnt = 0;
      mem_lat = 2;
      mem_en = 1'b1;
      force_ready = 1'b0;
      drop_rd = 1'b0;
      rst = 1'b1;
      ifc.Mem_Wr = 1'b0;
      ifc.Wr_Addr = '0;
      ifc.Wr_Data = '0;
      ifc.Rd_Miss_Req = 1'b0;
      ifc.Rd_Addr = '0;
      ifc.Main_Ready = 1'b0;

      vt[0] = '{addr: 10'h010, data: 32'h11,        lat: 2, burst: 1'b1, exp_empty: 1'b0};
      vt[1] = '{addr: 10'h020, data: 32'h22,        lat: 2, burst: 1'b1, exp_empty: 1'b0};
      vt[2] = '{addr: 10'h030, data: 32'h33,        lat: 2, burst: 1'b0, exp_empty: 1'b0};
      vt[3] = '{addr: 10'h3FF, data: 32'hFFFF_FFFF, lat: 1, burst: 1'b0, exp_empty: 1'b0};
      vt[4] = '{addr: 10'h000, data: 32'h0,         lat: 3, burst: 1'b0, exp_empty: 1'b0};
      vt[5] = '{addr: 10'h155, data: 32'hAAAA_AAAA, lat: 4, burst: 1'b0, exp_empty: 1'b0};
      vt[6] = '{addr: 10'h2AA, data: 32'h5555_5555, lat: 1, burst: 1'b0, exp_empty: 1'b0};

      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("rst_wb_empty",   {63'd0, ifc.wb_empty}, 64'd1);
      chk("rst_wb_full",    {63'd0, ifc.wb_full},  64'd0);
      chk("rst_main_wr",    {63'd0, ifc.Main_Wr},  64'd0);
      chk("rst_main_rd",    {63'd0, ifc.Main_Rd},  64'd0);
      chk("rst_rd_done",    {63'd0, ifc.Rd_Done},  64'd0);
      chk("rst_stall",      {63'd0, ifc.stall},    64'd0);
      chk("rst_main_addr",  {54'd0, ifc.Main_Addr},  64'd0);
      chk("rst_main_wdata", {32'd0, ifc.Main_WData}, 64'd0);

      // Table: stores in order, burst entries are queued back to back before draining.
      for (int i = 0; i < 7; i++) begin
         mem_lat = vt[i].lat;
         store(vt[i].addr, vt[i].data, 1'b1);
         chk("vec_empty_after_push", {63'd0, ifc.wb_empty}, {63'd0, vt[i].exp_empty});
         if (!vt[i].burst) begin
            wait_drain("vec_drain", 60);
            chk("vec_empty_after_drain", {63'd0, ifc.wb_empty}, 64'd1);
         end
      end

      // Back-pressure: fill while memory is stalled, then free exactly one slot.
      mem_en = 1'b0;
      force_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         store(ADDR_W'(32'h100 + i), DATA_W'(32'hB00 + i), 1'b1);
      chk("full_after_4", {63'd0, ifc.wb_full}, 64'd1);
      ifc.Mem_Wr  = 1'b1;
      ifc.Wr_Addr = 10'h104;
      ifc.Wr_Data = 32'hB04;
      #1;
      chk("stall_5th", {63'd0, ifc.stall}, 64'd1);
      tick();
      chk("full_hold",  {63'd0, ifc.wb_full}, 64'd1);
      chk("stall_hold", {63'd0, ifc.stall},   64'd1);
      mem_en = 1'b1;
      mem_lat = 1;
      n = 0;
      while (ifc.stall && n < 20) begin
         tick();
         n++;
      end
      chk("one_pop_not_full", {63'd0, ifc.wb_full}, 64'd0);
      sb.push_back('{is_rd: 1'b0, addr: 10'h104, data: 32'hB04});
      tick();
      ifc.Mem_Wr = 1'b0;
      chk("retry_accepted_full", {63'd0, ifc.wb_full}, 64'd1);
      wait_drain("full_drain", 80);

      // Non-hazard read overtakes the second queued store.
      mem_en = 1'b0;
      store(10'h040, 32'h44, 1'b0);
      store(10'h050, 32'h55, 1'b0);
      chk("t3_first_drain_active", {63'd0, ifc.Main_Wr}, 64'd1);
      sb.push_back('{is_rd: 1'b0, addr: 10'h040, data: 32'h44});
      sb.push_back('{is_rd: 1'b1, addr: 10'h077, data: '0});
      sb.push_back('{is_rd: 1'b0, addr: 10'h050, data: 32'h55});
      ifc.Rd_Miss_Req = 1'b1;
      ifc.Rd_Addr = 10'h077;
      base = rd_done_cnt;
      mem_en = 1'b1;
      mem_lat = 2;
      wait_drain("t3_drain", 60);
      chk("t3_rd_done_once", 64'(rd_done_cnt - base), 64'd1);

      // RAW hazard: read to a queued address waits for both drains.
      mem_en = 1'b0;
      store(10'h040, 32'h44, 1'b0);
      store(10'h050, 32'h55, 1'b0);
      sb.push_back('{is_rd: 1'b0, addr: 10'h040, data: 32'h44});
      sb.push_back('{is_rd: 1'b0, addr: 10'h050, data: 32'h55});
      sb.push_back('{is_rd: 1'b1, addr: 10'h050, data: '0});
      ifc.Rd_Miss_Req = 1'b1;
      ifc.Rd_Addr = 10'h050;
      base = rd_done_cnt;
      mem_en = 1'b1;
      mem_lat = 2;
      wait_drain("t4_drain", 60);
      chk("t4_rd_done_once", 64'(rd_done_cnt - base), 64'd1);

      // Reset in the middle of a stalled write discards the buffer.
      mem_en = 1'b0;
      force_ready = 1'b0;
      store(10'h0AA, 32'hAAA, 1'b0);
      store(10'h0BB, 32'hBBB, 1'b0);
      chk("t5_write_active", {63'd0, ifc.Main_Wr}, 64'd1);
      rst = 1'b1;
      tick();
      chk("t5_rst_main_wr",  {63'd0, ifc.Main_Wr},  64'd0);
      chk("t5_rst_wb_empty", {63'd0, ifc.wb_empty}, 64'd1);
      rst = 1'b0;
      force_ready = 1'b1;
      repeat (4) tick();
      chk("t5_no_pop_empty", {63'd0, ifc.wb_empty}, 64'd1);
      chk("t5_no_write",     {63'd0, ifc.Main_Wr},  64'd0);
      force_ready = 1'b0;
      tick();
      mem_en = 1'b1;

      // Store and read to the same word in the same IDLE cycle: store goes first.
      mem_lat = 1;
      ifc.Mem_Wr = 1'b1;
      ifc.Wr_Addr = 10'h060;
      ifc.Wr_Data = 32'h66;
      ifc.Rd_Miss_Req = 1'b1;
      ifc.Rd_Addr = 10'h060;
      sb.push_back('{is_rd: 1'b0, addr: 10'h060, data: 32'h66});
      sb.push_back('{is_rd: 1'b1, addr: 10'h060, data: '0});
      base = rd_done_cnt;
      tick();
      ifc.Mem_Wr = 1'b0;
      chk("t6_no_early_rd", {63'd0, ifc.Main_Rd}, 64'd0);
      wait_drain("t6_drain", 40);
      chk("t6_rd_done_once", 64'(rd_done_cnt - base), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
